// File: rtl/adc_capture_pkg.sv
// Shared constants and lane-extension helper for the ADC DDR capture block.
// Build with ADC_SIGN_EXTEND_EN defined to sign-extend narrow samples instead of zero-padding.
package adc_capture_pkg;

   localparam int LANE_W           = 16;
   localparam int STREAM_W         = 32;
   localparam int VALID_PIPE_DEPTH = 3;

`ifdef ADC_SIGN_EXTEND_EN
   localparam bit SIGN_EXT = 1'b1;
`else
   localparam bit SIGN_EXT = 1'b0;
`endif

   // Widens a sample of 'width' significant bits to a full lane.
   function automatic logic [LANE_W-1:0] pad_lane(input logic [LANE_W-1:0] sample, input int width);
      logic [LANE_W-1:0] lane;
      logic [3:0]        msb;
      lane = '0;
      msb  = 4'(width - 1);
      for (int i = 0; i < LANE_W; i++) begin
         if (i < width)
            lane[i] = sample[i];
         else
            lane[i] = SIGN_EXT ? sample[msb] : 1'b0;
      end
      return lane;
   endfunction

endpackage

// File: rtl/adc_ctrl_sync.sv
// Multi-bit flop-chain synchroniser for independent asynchronous level controls.
// Each bit is synchronised separately; there is no input register.
module adc_ctrl_sync #(
   parameter int WIDTH  = 2,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [STAGES-1:0][WIDTH-1:0] chain_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         chain_reg <= '0;
      else
         chain_reg <= {chain_reg[STAGES-2:0], din};
   end

   assign dout = chain_reg[STAGES-1];

endmodule

// File: rtl/adc_ddr_capture.sv
// DDR ADC bus capture: pairs rising/falling samples and streams them as 32-bit words.
// Lane extension is zero-pad by default, sign-extend when ADC_SIGN_EXTEND_EN is defined.
module adc_ddr_capture
   import adc_capture_pkg::*;
#(
   parameter int DATA_WIDTH          = 14,
   parameter int C_M_AXI_TDATA_WIDTH = 32,
   parameter int SYNC_STAGES         = 2
) (
   input  logic                           m_axi_aclk,
   input  logic                           m_axi_aresetn,
   input  logic [DATA_WIDTH-1:0]          adc_din,
   input  logic                           data_en,
   input  logic                           ddr_reset,
   output logic                           m_axi_tvalid,
   output logic [C_M_AXI_TDATA_WIDTH-1:0] m_axi_tdata,
   input  logic                           m_axi_tready
);

   logic [1:0]                     ctrl_s;
   logic                           en_s;
   logic                           rst_s;
   logic [DATA_WIDTH-1:0]          q1;
   logic [DATA_WIDTH-1:0]          q2;
   logic [STREAM_W-1:0]            word;
   logic [C_M_AXI_TDATA_WIDTH-1:0] tdata_reg;
   logic [VALID_PIPE_DEPTH-1:0]    valid_pipe_reg;

   adc_ctrl_sync #(
      .WIDTH  (2),
      .STAGES (SYNC_STAGES)
   ) u_ctrl_sync (
      .clk   (m_axi_aclk),
      .rst_n (m_axi_aresetn),
      .din   ({data_en, ddr_reset}),
      .dout  (ctrl_s)
   );

   assign en_s  = ctrl_s[1];
   assign rst_s = ctrl_s[0];

   // Per-bit capture: the falling sample is retimed with its rising partner so both land in q together.
   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      logic rise_reg;
      logic fall_reg;
      logic q1_reg;
      logic q2_reg;

      always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
         if (!m_axi_aresetn) begin
            rise_reg <= 1'b0;
            q1_reg   <= 1'b0;
            q2_reg   <= 1'b0;
         end else if (rst_s) begin
            rise_reg <= 1'b0;
            q1_reg   <= 1'b0;
            q2_reg   <= 1'b0;
         end else if (en_s) begin
            rise_reg <= adc_din[gi];
            q1_reg   <= rise_reg;
            q2_reg   <= fall_reg;
         end
      end

      always_ff @(negedge m_axi_aclk or negedge m_axi_aresetn) begin
         if (!m_axi_aresetn)
            fall_reg <= 1'b0;
         else if (rst_s)
            fall_reg <= 1'b0;
         else if (en_s)
            fall_reg <= adc_din[gi];
      end

      assign q1[gi] = q1_reg;
      assign q2[gi] = q2_reg;
   end

   assign word = {pad_lane(LANE_W'(q1), DATA_WIDTH), pad_lane(LANE_W'(q2), DATA_WIDTH)};

   // No skid storage: any idle cycle flushes the word and restarts the valid fill.
   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         tdata_reg      <= '0;
         valid_pipe_reg <= '0;
      end else if (m_axi_tready && en_s) begin
         tdata_reg      <= word;
         valid_pipe_reg <= {en_s, valid_pipe_reg[VALID_PIPE_DEPTH-1:1]};
      end else begin
         tdata_reg      <= '0;
         valid_pipe_reg <= '0;
      end
   end

   assign m_axi_tdata  = tdata_reg;
   assign m_axi_tvalid = valid_pipe_reg[0];

endmodule

// File: tb/tb_adc_ddr_capture.sv
// Scoreboard bench for adc_ddr_capture: stimulus queues expected words, a monitor checks each valid beat.
// Expected lane values follow ADC_SIGN_EXTEND_EN when it is defined for the build.
module tb_adc_ddr_capture;

   localparam logic [13:0] R0 = 14'h1234;
   localparam logic [13:0] F0 = 14'h0ABC;
   localparam logic [31:0] W0 = 32'h12340ABC;
   localparam logic [31:0] W_HALF = 32'h00000ABC;
   localparam logic [31:0] MIX1 = 32'h12341FFF;
`ifdef ADC_SIGN_EXTEND_EN
   localparam logic [31:0] S1   = 32'hE0011FFF;
   localparam logic [31:0] MIX2 = 32'hE0010000;
   localparam logic [31:0] S2   = 32'hFFFF0000;
`else
   localparam logic [31:0] S1   = 32'h20011FFF;
   localparam logic [31:0] MIX2 = 32'h20010000;
   localparam logic [31:0] S2   = 32'h3FFF0000;
`endif

   logic        clk;
   logic        rst_n;
   logic [13:0] adc_din;
   logic        data_en;
   logic        ddr_reset;
   logic        m_axi_tvalid;
   logic [31:0] m_axi_tdata;
   logic        m_axi_tready;

   logic [13:0] rise_val;
   logic [13:0] fall_val;
   logic [31:0] exp_q[$];
   int          checks;
   int          passes;

   adc_ddr_capture #(
      .DATA_WIDTH          (14),
      .C_M_AXI_TDATA_WIDTH (32),
      .SYNC_STAGES         (2)
   ) dut (
      .m_axi_aclk    (clk),
      .m_axi_aresetn (rst_n),
      .adc_din       (adc_din),
      .data_en       (data_en),
      .ddr_reset     (ddr_reset),
      .m_axi_tvalid  (m_axi_tvalid),
      .m_axi_tdata   (m_axi_tdata),
      .m_axi_tready  (m_axi_tready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising-edge sample is presented after each falling edge, falling-edge sample after each rising edge.
   initial begin
      adc_din = '0;
      forever begin
         @(posedge clk);
         #2 adc_din = fall_val;
         @(negedge clk);
         #2 adc_din = rise_val;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Monitor: every valid beat must match the oldest queued expectation.
   initial begin
      logic [31:0] exp;
      forever begin
         @(negedge clk);
         if (rst_n && m_axi_tvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL beat_unexpected: got tdata=%08h, required no valid beat", m_axi_tdata);
            end else begin
               exp = exp_q.pop_front();
               if (m_axi_tdata !== exp)
                  $display("FAIL beat_data: got tdata=%08h, required %08h", m_axi_tdata, exp);
               else begin
                  passes++;
                  $display("beat tdata=%08h ok", m_axi_tdata);
               end
            end
         end
      end
   end

   // One rising edge; ev/ew state whether that edge should present a valid beat and its word.
   task automatic tick(input logic ev, input logic [31:0] ew, input bit chk_zero, input string tag);
      if (ev)
         exp_q.push_back(ew);
      @(posedge clk);
      #1;
      checks++;
      if (m_axi_tvalid !== ev)
         $display("FAIL %s tvalid: got %0b, required %0b", tag, m_axi_tvalid, ev);
      else
         passes++;
      if (chk_zero) begin
         checks++;
         if (m_axi_tdata !== 32'h0)
            $display("FAIL %s tdata: got %08h, required 00000000", tag, m_axi_tdata);
         else
            passes++;
      end
   endtask

   initial begin
      checks       = 0;
      passes       = 0;
      rst_n        = 1'b0;
      data_en      = 1'b1;
      ddr_reset    = 1'b0;
      m_axi_tready = 1'b1;
      rise_val     = R0;
      fall_val     = F0;

      repeat (4) tick(1'b0, 32'h0, 1'b1, "reset_hold");
      rst_n = 1'b1;
      // Two sync edges then a three-edge fill: first valid beat on the fifth edge.
      repeat (4) tick(1'b0, 32'h0, 1'b0, "post_reset_fill");
      repeat (4) tick(1'b1, W0, 1'b0, "stream");

      m_axi_tready = 1'b0;
      tick(1'b0, 32'h0, 1'b1, "bp_drop");
      m_axi_tready = 1'b1;
      repeat (2) tick(1'b0, 32'h0, 1'b0, "bp_refill");
      repeat (2) tick(1'b1, W0, 1'b0, "bp_resume");

      data_en = 1'b0;
      repeat (2) tick(1'b1, W0, 1'b0, "en_off_sync");
      repeat (2) tick(1'b0, 32'h0, 1'b1, "en_off");
      data_en = 1'b1;
      repeat (4) tick(1'b0, 32'h0, 1'b0, "en_latency");
      repeat (2) tick(1'b1, W0, 1'b0, "en_on");

      // Four-cycle capture reset: stale words drain, zeros while reset holds, lower lane recovers first.
      ddr_reset = 1'b1;
      repeat (3) tick(1'b1, W0, 1'b0, "crst_drain");
      tick(1'b1, 32'h0, 1'b0, "crst_zero");
      ddr_reset = 1'b0;
      repeat (3) tick(1'b1, 32'h0, 1'b0, "crst_zero");
      tick(1'b1, W_HALF, 1'b0, "crst_recover");
      repeat (2) tick(1'b1, W0, 1'b0, "crst_resume");

      data_en = 1'b0;
      repeat (2) tick(1'b1, W0, 1'b0, "both_prep");
      repeat (2) tick(1'b0, 32'h0, 1'b1, "both_prep_off");
      data_en   = 1'b1;
      ddr_reset = 1'b1;
      repeat (4) tick(1'b0, 32'h0, 1'b0, "both_fill");
      repeat (2) tick(1'b1, 32'h0, 1'b0, "both_zero");
      ddr_reset = 1'b0;
      repeat (3) tick(1'b1, 32'h0, 1'b0, "both_release");
      tick(1'b1, W_HALF, 1'b0, "both_recover");
      tick(1'b1, W0, 1'b0, "both_resume");

      rise_val = 14'h2001;
      fall_val = 14'h1FFF;
      tick(1'b1, W0, 1'b0, "ext_old");
      tick(1'b1, MIX1, 1'b0, "ext_mix1");
      repeat (2) tick(1'b1, S1, 1'b0, "ext_s1");
      rise_val = 14'h3FFF;
      fall_val = 14'h0000;
      tick(1'b1, S1, 1'b0, "ext_s1_tail");
      tick(1'b1, MIX2, 1'b0, "ext_mix2");
      repeat (2) tick(1'b1, S2, 1'b0, "ext_s2");

      // Asynchronous reset mid-cycle while streaming.
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (m_axi_tvalid !== 1'b0 || m_axi_tdata !== 32'h0)
         $display("FAIL async_reset: got tvalid=%0b tdata=%08h, required 0 and 00000000", m_axi_tvalid, m_axi_tdata);
      else
         passes++;

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0)
         $display("FAIL scoreboard_drain: got %0d pending words, required 0", exp_q.size());
      else
         passes++;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
